conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Top-level sequencer for the 8-point direct-form convolver.
- For each output index n = 0..2*N_TAPS-2, it walks every valid index pair (i, n-i): x_idx = i, h_idx = n-i.
- For each pair it issues one multiply to the shared Booth multiplier, sign-extends and accumulates the product, then emits y[n] on a valid/ready output port.
- Sample storage lives outside this block; x_idx/h_idx drive the sample-memory read lines.

Parameters:
- N_TAPS, 8, samples per input sequence (both x and h).
- IDX_W, 3, index width, equal to clog2(N_TAPS).
- DATA_W, 8, signed sample width; products are 2*DATA_W.
- ACC_W, 19, signed accumulator / y_data width. Default 2*DATA_W+3 never overflows.
- OUT_IDX_W, 4, y_idx width; must hold 2*N_TAPS-2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a full convolution; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last y[n] handshake
- x_idx  out  IDX_W  x sample select
- h_idx  out  IDX_W  h sample select
- mul_start  out  1  one-cycle multiply request
- mul_done  in  1  multiplier result valid, one cycle
- mul_product  in  2*DATA_W  signed product, valid with mul_done
- y_data  out  ACC_W  signed y[n]
- y_idx  out  OUT_IDX_W  n of y_data
- y_valid  out  1  y_data/y_idx valid
- y_ready  in  1  downstream accepts

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; n, i and acc are cleared.
  - All outputs are 0: busy, done, mul_start, y_valid, x_idx, h_idx, y_data, y_idx.
  - Asserting reset mid-operation aborts the run. No done pulse is generated and no partial y is emitted.
- States and transitions:
  - IDLE: when start=1, set n=0 and go to SETUP. busy=0.
  - SETUP (1 cycle):
    - i_lo = max(0, n-(N_TAPS-1)); i_hi = min(n, N_TAPS-1).
    - Set i=i_lo and acc=0, then go to ISSUE.
  - ISSUE (1 cycle): drive x_idx=i, h_idx=n-i, mul_start=1, then go to WAIT_MUL.
    - x_idx/h_idx stay stable from ISSUE until mul_done.
  - WAIT_MUL: wait for mul_done.
    - On mul_done, acc <= acc + sext(mul_product).
    - If i==i_hi, go to EMIT; otherwise i <= i+1 and go to ISSUE.
  - EMIT:
    - y_valid=1, y_data=acc, y_idx=n. These hold stable until y_ready=1.
    - On the handshake cycle: if n==2*N_TAPS-2, go to FINISH; otherwise n <= n+1 and go to SETUP.
    - y_valid drops the cycle after the handshake.
  - FINISH: done=1 for exactly one cycle, then go to IDLE.
- Pairs per output: i_hi-i_lo+1, i.e. 1,2,...,8,...,2,1 for N_TAPS=8. Total mul_start pulses per run = N_TAPS^2 = 64.
- Latency, with a multiplier of latency L (mul_done L cycles after mul_start) and y_ready held high: each y[n] costs 1 + P*(1+L) + 1 cycles, where P is the pair count for that n.
- Ignored inputs and events:
  - start while busy=1 is ignored.
  - mul_done outside WAIT_MUL is ignored.
  - mul_done in the same cycle as mul_start is not possible; mul_start occurs only in ISSUE.
- Arithmetic: two's complement. mul_product is sign-extended to ACC_W before the add. Accumulation wraps modulo 2^ACC_W unless ACC_SAT_EN is defined.
- Back-to-back runs: start asserted in the cycle after done is accepted.

Optional Feature:
- Macro: CONV_SEQ_ACC_SAT_EN.
- Defined: each accumulate saturates to the signed range of ACC_W (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)). Saturation is sticky for the current n only and clears in SETUP.
- Undefined: wrap-around add. No saturation logic is present.

Test Plan:
- x=h=all 1, L=0, y_ready=1:
  - y_idx 0..14 appear in order.
  - y_data = 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1.
  - 64 mul_start pulses, one done pulse.
  - Inter-run check: start again after done gives identical output.
- x=[1..8], h=[1,0,0,0,0,0,0,0], L=5:
  - y_data[n] = x[n] for n≤7 and 0 for n≥8.
  - Pair sequence checked; x_idx/h_idx are stable throughout WAIT_MUL.
- Backpressure on y[3]: hold y_ready=0 for 10 cycles.
  - y_valid, y_data=4 and y_idx=3 are held constant.
  - No mul_start is issued until the handshake.
- Reset mid-run: deassert rst_n during n=6 WAIT_MUL.
  - All outputs go to 0 immediately (async).
  - No done pulse.
  - A subsequent start produces a full correct run.
- Control glitches:
  - start pulses while busy are ignored (y sequence unchanged).
  - A spurious mul_done in EMIT does not change acc.
- ACC_W=8, x=h=all -128 (product 16384), signed check on y[7] (8 pairs):
  - With CONV_SEQ_ACC_SAT_EN: y[7]=127.
  - Without it: y[7] = wrapped value 0.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: control sequencer for an N_TAPS-point direct-form convolver.
// For every output index n it walks the valid (x_idx, h_idx) pairs, issues one
// multiply per pair to an external multiplier, accumulates the sign-extended
// products and presents y[n] on a valid/ready port.
// Optional build macro CONV_SEQ_ACC_SAT_EN: saturating accumulation with a
// sticky per-output saturation flag; without it the accumulator wraps.
`timescale 1ns/1ps

module conv_sequencer #(
  parameter int N_TAPS    = 8,
  parameter int IDX_W     = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 19,
  parameter int OUT_IDX_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [IDX_W-1:0]           x_idx,
  output logic [IDX_W-1:0]           h_idx,
  output logic                       mul_start,
  input  logic                       mul_done,
  input  logic signed [2*DATA_W-1:0] mul_product,
  output logic signed [ACC_W-1:0]    y_data,
  output logic [OUT_IDX_W-1:0]       y_idx,
  output logic                       y_valid,
  input  logic                       y_ready
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [OUT_IDX_W-1:0] LAST_N   = OUT_IDX_W'(2 * N_TAPS - 2);
  localparam logic [OUT_IDX_W-1:0] TOP_N    = OUT_IDX_W'(N_TAPS - 1);
  localparam logic [IDX_W-1:0]     TOP_I    = IDX_W'(N_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT_MUL,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t                  state, state_nx;
  logic [OUT_IDX_W-1:0]    n, n_nx;
  logic [IDX_W-1:0]        i, i_nx;
  logic [IDX_W-1:0]        i_hi, i_hi_nx;
  logic signed [ACC_W-1:0] acc, acc_nx;

  // Pair bounds and h index; the true values always fit in IDX_W bits, so
  // modular arithmetic on the low bits of n gives the exact result.
  logic [IDX_W-1:0]        i_lo_calc, i_hi_calc, h_calc;
  logic signed [ACC_W-1:0] acc_add;

  assign h_calc    = n[IDX_W-1:0] - i;
  assign i_lo_calc = (n > TOP_N) ? (n[IDX_W-1:0] - TOP_I) : '0;
  assign i_hi_calc = (n < TOP_N) ? n[IDX_W-1:0] : TOP_I;

`ifdef CONV_SEQ_ACC_SAT_EN
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX =
    {{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    {{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

  logic signed [SUM_W-1:0] sum;
  logic                    sat;
  logic                    sat_hit;

  assign sum     = SUM_W'(acc) + SUM_W'(mul_product);
  assign sat_hit = (sum > ACC_MAX) || (sum < ACC_MIN);

  // Clamp the wide sum to the accumulator range; once clamped, hold for this n
  always_comb begin
    acc_add = sum[ACC_W-1:0];
    if (sat)
      acc_add = acc;
    else if (sum > ACC_MAX)
      acc_add = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN)
      acc_add = ACC_MIN[ACC_W-1:0];
  end

  // Sticky saturation flag, cleared when a new output index is set up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat <= 1'b0;
    else if (state == S_SETUP)
      sat <= 1'b0;
    else if ((state == S_WAIT_MUL) && mul_done && sat_hit)
      sat <= 1'b1;
  end
`else
  // Plain two's complement accumulate; the cast sign-extends or truncates
  assign acc_add = acc + ACC_W'(mul_product);
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      n     <= '0;
      i     <= '0;
      i_hi  <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      i     <= i_nx;
      i_hi  <= i_hi_nx;
      acc   <= acc_nx;
    end
  end

  // Next-state and output decode; outputs are zero outside their owning state
  always_comb begin
    state_nx  = state;
    n_nx      = n;
    i_nx      = i;
    i_hi_nx   = i_hi;
    acc_nx    = acc;
    busy      = 1'b1;
    done      = 1'b0;
    mul_start = 1'b0;
    y_valid   = 1'b0;
    x_idx     = '0;
    h_idx     = '0;
    y_data    = '0;
    y_idx     = '0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          n_nx     = '0;
          state_nx = S_SETUP;
        end
      end

      S_SETUP: begin
        i_nx     = i_lo_calc;
        i_hi_nx  = i_hi_calc;
        acc_nx   = '0;
        state_nx = S_ISSUE;
      end

      S_ISSUE: begin
        x_idx     = i;
        h_idx     = h_calc;
        mul_start = 1'b1;
        state_nx  = S_WAIT_MUL;
      end

      S_WAIT_MUL: begin
        x_idx = i;
        h_idx = h_calc;
        if (mul_done) begin
          acc_nx = acc_add;
          if (i == i_hi) begin
            state_nx = S_EMIT;
          end else begin
            i_nx     = i + 1'b1;
            state_nx = S_ISSUE;
          end
        end
      end

      S_EMIT: begin
        y_valid = 1'b1;
        y_data  = acc;
        y_idx   = n;
        if (y_ready) begin
          if (n == LAST_N) begin
            state_nx = S_FINISH;
          end else begin
            n_nx     = n + 1'b1;
            state_nx = S_SETUP;
          end
        end
      end

      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench for conv_sequencer with a behavioural
// multiplier of programmable latency, plus a narrow-accumulator instance
// (ACC_W=8) exercising wrap / saturation (CONV_SEQ_ACC_SAT_EN).
`timescale 1ns/1ps

module tb_conv_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               busy, done;
  logic [2:0]         x_idx, h_idx;
  logic               mul_start;
  logic               mul_done = 1'b0;
  logic signed [15:0] mul_product = '0;
  logic signed [18:0] y_data;
  logic [3:0]         y_idx;
  logic               y_valid;
  logic               y_ready = 1'b1;

  // Narrow-accumulator instance signals
  logic               start8 = 1'b0;
  logic               busy8, done8;
  logic [2:0]         x_idx8, h_idx8;
  logic               mul_start8;
  logic               mul_done8 = 1'b0;
  logic signed [15:0] mul_product8 = '0;
  logic signed [7:0]  y_data8;
  logic [3:0]         y_idx8;
  logic               y_valid8;
  logic               y_ready8 = 1'b1;

  logic signed [7:0]  x_mem [8];
  logic signed [7:0]  h_mem [8];
  logic signed [7:0]  mem8  [8];

  int  vectors = 0;
  int  miscompares = 0;
  int  mul_lat = 0;
  bit  pend = 1'b0;
  int  pend_cnt = 0;
  logic [2:0] cap_x = '0, cap_h = '0;
  logic signed [15:0] prod_r = '0;
  int  mul_cnt = 0;
  int  pair_x_log [2048];
  int  pair_h_log [2048];
  int  y_cnt = 0;
  int  y_idx_log [512];
  int  y_data_log [512];
  int  done_cnt = 0;
  int  idx_unstable = 0;
  int  spur_req = 0;
  int  spur_seen = 0;
  bit  pend8 = 1'b0;

  conv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .x_idx(x_idx), .h_idx(h_idx), .mul_start(mul_start), .mul_done(mul_done),
    .mul_product(mul_product), .y_data(y_data), .y_idx(y_idx),
    .y_valid(y_valid), .y_ready(y_ready)
  );

  conv_sequencer #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .x_idx(x_idx8), .h_idx(h_idx8), .mul_start(mul_start8), .mul_done(mul_done8),
    .mul_product(mul_product8), .y_data(y_data8), .y_idx(y_idx8),
    .y_valid(y_valid8), .y_ready(y_ready8)
  );

  always #5 clk = ~clk;

  // Multiplier model: result mul_lat cycles after the first WAIT_MUL cycle; also
  // logs issued pairs, checks index stability and injects spurious mul_done
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        = 1'b0;
      mul_done    = 1'b0;
      mul_product = '0;
    end else begin
      mul_done = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen   = spur_req;
        mul_done    = 1'b1;
        mul_product = 16'sd100;
      end
      if (pend) begin
        if (x_idx !== cap_x || h_idx !== cap_h) idx_unstable++;
        if (pend_cnt == 0) begin
          mul_done    = 1'b1;
          mul_product = prod_r;
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mul_start === 1'b1) begin
        pend     = 1'b1;
        pend_cnt = mul_lat;
        cap_x    = x_idx;
        cap_h    = h_idx;
        prod_r   = x_mem[x_idx] * h_mem[h_idx];
        if (mul_cnt < 2048) begin
          pair_x_log[mul_cnt] = 32'(x_idx);
          pair_h_log[mul_cnt] = 32'(h_idx);
        end
        mul_cnt++;
      end
    end
  end

  // Output monitor: records every y handshake and counts done pulses
  always @(negedge clk) begin
    if (rst_n && y_valid === 1'b1 && y_ready === 1'b1) begin
      if (y_cnt < 512) begin
        y_idx_log[y_cnt]  = 32'(y_idx);
        y_data_log[y_cnt] = 32'(y_data);
      end
      y_cnt++;
    end
    if (rst_n && done === 1'b1) done_cnt++;
  end

  // Single-cycle multiplier for the narrow instance
  always @(negedge clk) begin
    mul_done8    = pend8;
    mul_product8 = pend8 ? (mem8[x_idx8] * mem8[h_idx8]) : 16'sd0;
    pend8        = (mul_start8 === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int refY(input int n);
    int s = 0;
    for (int k = 0; k < 8; k++)
      if (n - k >= 0 && n - k < 8) s += x_mem[k] * h_mem[n - k];
    return s;
  endfunction

  task automatic applyStimulus(input int lat);
    int guard = 0;
    mul_lat = lat;
    start = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (busy !== 1'b1 && guard < 10);
    start = 1'b0;
    checkOutput("start_accept", 32'(busy), 1);
  endtask

  task automatic waitDone();
    bit ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitY(input int idx);
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (y_valid === 1'b1 && 32'(y_idx) == idx) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("wait_y%0d", idx), 32'(ok), 1);
  endtask

  task automatic checkRun(input string tag, input int base_y, input int base_mul,
                          input int base_done);
    int p = base_mul;
    int errs = 0;
    int lo, hi;
    checkOutput({tag, " y_count"}, y_cnt - base_y, 15);
    for (int n = 0; n < 15; n++) begin
      checkOutput($sformatf("%s y_idx[%0d]", tag, n), y_idx_log[base_y + n], n);
      checkOutput($sformatf("%s y_data[%0d]", tag, n), y_data_log[base_y + n], refY(n));
    end
    checkOutput({tag, " mul_count"}, mul_cnt - base_mul, 64);
    checkOutput({tag, " done_count"}, done_cnt - base_done, 1);
    for (int n = 0; n < 15; n++) begin
      lo = (n > 7) ? n - 7 : 0;
      hi = (n < 7) ? n : 7;
      for (int i = lo; i <= hi; i++) begin
        if (p >= 2048 || pair_x_log[p] != i || pair_h_log[p] != n - i) errs++;
        p++;
      end
    end
    checkOutput({tag, " pair_seq_errs"}, errs, 0);
  endtask

  initial begin
    int by, bm, bd, bu, mc, hold_err, y0_8, y7_8;
    bit ok8;

    for (int k = 0; k < 8; k++) begin
      x_mem[k] = 8'sd1;
      h_mem[k] = 8'sd1;
      mem8[k]  = 8'sh80;
    end

    // Asynchronous reset: every output zero before any clock edge
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_ctrl", 32'({busy, done, mul_start, y_valid}), 0);
    checkOutput("reset_idx", 32'({x_idx, h_idx, y_idx}), 0);
    checkOutput("reset_y_data", 32'(y_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-ones sequences, immediate multiplier, then a back-to-back rerun
    by = y_cnt; bm = mul_cnt; bd = done_cnt;
    applyStimulus(0);
    waitDone();
    checkRun("ones", by, bm, bd);
    by = y_cnt; bm = mul_cnt; bd = done_cnt;
    applyStimulus(0);
    waitDone();
    checkRun("ones_rerun", by, bm, bd);

    // Backpressure on y[3] with a spurious mul_done during the stall
    by = y_cnt; bm = mul_cnt; bd = done_cnt;
    applyStimulus(0);
    waitY(2);
    @(posedge clk);
    #1 y_ready = 1'b0;
    waitY(3);
    mc = mul_cnt;
    hold_err = 0;
    spur_req++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!(y_valid === 1'b1 && y_data === 19'sd4 && y_idx === 4'd3)) hold_err++;
    end
    checkOutput("bp_hold_errs", hold_err, 0);
    checkOutput("bp_no_mul", mul_cnt - mc, 0);
    @(posedge clk);
    #1 y_ready = 1'b1;
    waitDone();
    checkRun("backpressure", by, bm, bd);

    // Ramp x against a unit impulse h, latency 5, with start pulses while busy
    for (int k = 0; k < 8; k++) begin
      x_mem[k] = 8'(k + 1);
      h_mem[k] = (k == 0) ? 8'sd1 : 8'sd0;
    end
    by = y_cnt; bm = mul_cnt; bd = done_cnt; bu = idx_unstable;
    applyStimulus(5);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (150) @(posedge clk);
    #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    waitDone();
    checkRun("impulse", by, bm, bd);
    checkOutput("idx_stable_errs", idx_unstable - bu, 0);

    // Reset during the n=6 multiply wait, then a clean run
    for (int k = 0; k < 8; k++) begin
      x_mem[k] = 8'sd1;
      h_mem[k] = 8'sd1;
    end
    by = y_cnt; bd = done_cnt;
    applyStimulus(2);
    ok8 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (pend && mul_start === 1'b0 && (32'(x_idx) + 32'(h_idx) == 6)) begin
        ok8 = 1'b1;
        break;
      end
    end
    checkOutput("wait_n6", 32'(ok8), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 32'({busy, done, mul_start, y_valid}), 0);
    checkOutput("midrst_idx", 32'({x_idx, h_idx, y_idx}), 0);
    checkOutput("midrst_y_data", 32'(y_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", done_cnt - bd, 0);
    checkOutput("midrst_y_count", y_cnt - by, 6);
    by = y_cnt; bm = mul_cnt; bd = done_cnt;
    applyStimulus(0);
    waitDone();
    checkRun("after_reset", by, bm, bd);

    // Narrow accumulator: 8 products of 16384 into 8 bits
    y0_8 = -1;
    y7_8 = -1;
    ok8 = 1'b0;
    start8 = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy8 === 1'b1) start8 = 1'b0;
      if (y_valid8 === 1'b1 && y_idx8 === 4'd0) y0_8 = 32'(y_data8);
      if (y_valid8 === 1'b1 && y_idx8 === 4'd7) y7_8 = 32'(y_data8);
      if (done8 === 1'b1) begin
        ok8 = 1'b1;
        break;
      end
    end
    start8 = 1'b0;
    checkOutput("acc8_done", 32'(ok8), 1);
`ifdef CONV_SEQ_ACC_SAT_EN
    checkOutput("acc8_y0_sat", y0_8, 127);
    checkOutput("acc8_y7_sat", y7_8, 127);
`else
    checkOutput("acc8_y0_wrap", y0_8, 0);
    checkOutput("acc8_y7_wrap", y7_8, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
